fp_mul_pipe: RTL and testbench

- Pipelined IEEE-style floating-point multiplier, parameterised by exponent and mantissa width.
- Produces the packed sign+exp+mant words consumed downstream by the float display/debug monitor and the TPU accumulate path.
- Three register stages with a valid/ready handshake on both sides.
- Subnormal inputs and results are flushed to zero (FTZ). Rounding is round-to-nearest-even (RNE).

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_round_pack.sv | 64 ++++++
 rtl/fp_mul_pipe.sv | 191 +++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, exponent bias,
// canonical quiet NaN and status-flag bit positions.
package fp_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  localparam int FLAG_BITS      = 5;
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_OVERFLOW  = 3;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_INEXACT   = 1;
  localparam int FLAG_DENORM    = 0;

  function automatic int bias(input int exp_bits);
    return (1 << (exp_bits - 1)) - 1;
  endfunction

  // Returned left-aligned in 64 bits; callers truncate to their word width.
  function automatic logic [63:0] qnan(input int exp_bits, input int mant_bits);
    logic [63:0] r;
    r = ((64'd1 << exp_bits) - 64'd1) << mant_bits;
    r = r | (64'd1 << (mant_bits - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalize a raw significand product, round to nearest-even, then
// saturate to infinity or flush to zero and pack {sign, exp, mant}.
module fp_round_pack #(
  parameter int  EXP_BITS  = 8,
  parameter int  MANT_BITS = 23,
  localparam int W         = EXP_BITS + MANT_BITS + 1,
  localparam int XW        = EXP_BITS + 2,
  localparam int PW        = 2 * MANT_BITS + 2
) (
  input  logic                 i_sign,
  input  logic signed [XW-1:0] i_exp,
  input  logic [PW-1:0]        i_prod,
  output logic [W-1:0]         o_data,
  output logic                 o_overflow,
  output logic                 o_underflow,
  output logic                 o_inexact
);

  localparam logic signed [XW-1:0] ONE     = XW'(1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_BITS) - 1);

  // Hidden bit already stripped: w_norm holds fraction, guard and sticky bits.
  logic [PW-2:0]         w_norm;
  logic signed [XW-1:0]  w_exp_n;
  logic signed [XW-1:0]  w_exp_r;
  logic [MANT_BITS-1:0]  w_mant;
  logic [MANT_BITS:0]    w_mant_r;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_rnd;

  always_comb begin
    if (i_prod[PW-1]) begin
      w_norm  = i_prod[PW-2:0];
      w_exp_n = i_exp + ONE;
    end else begin
      w_norm  = {i_prod[PW-3:0], 1'b0};
      w_exp_n = i_exp;
    end
    w_mant   = w_norm[PW-2 -: MANT_BITS];
    w_guard  = w_norm[MANT_BITS];
    w_sticky = |w_norm[MANT_BITS-1:0];
    w_rnd    = w_guard && (w_sticky || w_mant[0]);
    w_mant_r = {1'b0, w_mant} + {{MANT_BITS{1'b0}}, w_rnd};
    // Carry out leaves the fraction at zero; only the exponent moves.
    w_exp_r  = w_mant_r[MANT_BITS] ? (w_exp_n + ONE) : w_exp_n;

    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    o_inexact   = w_guard || w_sticky;
    if (w_exp_r >= EXP_MAX) begin
      o_data     = {i_sign, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
      o_overflow = 1'b1;
      o_inexact  = 1'b1;
    end else if (w_exp_r < ONE) begin
      o_data      = {i_sign, {(W-1){1'b0}}};
      o_underflow = 1'b1;
      o_inexact   = 1'b1;
    end else begin
      o_data = {i_sign, w_exp_r[EXP_BITS-1:0], w_mant_r[MANT_BITS-1:0]};
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage FTZ/RNE floating-point multiplier with a single global stall.
// Define FP_MUL_PIPE_STATUS_EN to add the registered out_flags status port.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int  EXP_BITS  = 8,
  parameter int  MANT_BITS = 23,
  localparam int W         = EXP_BITS + MANT_BITS + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_a,
  input  logic [W-1:0]         in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data
`ifdef FP_MUL_PIPE_STATUS_EN
  ,
  output logic [FLAG_BITS-1:0] out_flags
`endif
);

  localparam int XW = EXP_BITS + 2;
  localparam int PW = 2 * MANT_BITS + 2;
  localparam logic signed [XW-1:0] BIAS_X = XW'(bias(EXP_BITS));
  localparam logic [W-1:0]         QNAN   = W'(qnan(EXP_BITS, MANT_BITS));

  function automatic fp_class_e classify(input logic [EXP_BITS-1:0] e,
                                         input logic [MANT_BITS-1:0] m);
    if (e == '0) return CLS_ZERO;
    if (&e) return (m == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  logic w_adv;
  logic r1_valid, r2_valid, r3_valid;

  assign w_adv     = !r3_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r3_valid;

  // S1: unpack and classify
  logic [EXP_BITS-1:0]  w_ea, w_eb;
  logic [MANT_BITS-1:0] w_ma, w_mb;
  fp_class_e            w_cls_a, w_cls_b;
  logic signed [XW-1:0] w_exp_sum;

  assign w_ea      = in_a[W-2:MANT_BITS];
  assign w_eb      = in_b[W-2:MANT_BITS];
  assign w_ma      = in_a[MANT_BITS-1:0];
  assign w_mb      = in_b[MANT_BITS-1:0];
  assign w_cls_a   = classify(w_ea, w_ma);
  assign w_cls_b   = classify(w_eb, w_mb);
  assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS_X;

  logic                 r1_sign;
  fp_class_e            r1_cls_a, r1_cls_b;
  logic signed [XW-1:0] r1_exp;
  logic [MANT_BITS:0]   r1_ma, r1_mb;

  logic                 r2_sign;
  fp_class_e            r2_cls_a, r2_cls_b;
  logic signed [XW-1:0] r2_exp;
  logic [PW-1:0]        r2_prod;

  logic [W-1:0]         r3_data;

  always_ff @(posedge clk) begin
    if (w_adv) begin
      if (in_valid) begin
        r1_sign  <= in_a[W-1] ^ in_b[W-1];
        r1_cls_a <= w_cls_a;
        r1_cls_b <= w_cls_b;
        r1_exp   <= w_exp_sum;
        r1_ma    <= {1'b1, w_ma};
        r1_mb    <= {1'b1, w_mb};
      end
      if (r1_valid) begin
        r2_sign  <= r1_sign;
        r2_cls_a <= r1_cls_a;
        r2_cls_b <= r1_cls_b;
        r2_exp   <= r1_exp;
        r2_prod  <= PW'(r1_ma) * PW'(r1_mb);
      end
    end
  end

  // S3: round/pack, then special-case override
  logic [W-1:0] w_rp_data;
  logic         w_rp_ovf, w_rp_unf, w_rp_inx;
  logic         w_nan_any, w_inf_any, w_zero_any, w_inf_zero, w_special;
  logic [W-1:0] w_res;

  fp_round_pack #(
    .EXP_BITS  (EXP_BITS),
    .MANT_BITS (MANT_BITS)
  ) u_round_pack (
    .i_sign      (r2_sign),
    .i_exp       (r2_exp),
    .i_prod      (r2_prod),
    .o_data      (w_rp_data),
    .o_overflow  (w_rp_ovf),
    .o_underflow (w_rp_unf),
    .o_inexact   (w_rp_inx)
  );

  always_comb begin
    w_nan_any  = (r2_cls_a == CLS_NAN)  || (r2_cls_b == CLS_NAN);
    w_inf_any  = (r2_cls_a == CLS_INF)  || (r2_cls_b == CLS_INF);
    w_zero_any = (r2_cls_a == CLS_ZERO) || (r2_cls_b == CLS_ZERO);
    w_inf_zero = w_inf_any && w_zero_any;
    w_special  = 1'b1;
    if (w_nan_any || w_inf_zero) begin
      w_res = QNAN;
    end else if (w_inf_any) begin
      w_res = {r2_sign, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
    end else if (w_zero_any) begin
      w_res = {r2_sign, {(W-1){1'b0}}};
    end else begin
      w_res     = w_rp_data;
      w_special = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r3_valid <= 1'b0;
      r3_data  <= '0;
    end else if (w_adv) begin
      r1_valid <= in_valid;
      r2_valid <= r1_valid;
      r3_valid <= r2_valid;
      if (r2_valid) r3_data <= w_res;
    end
  end

  assign out_data = r3_data;

`ifdef FP_MUL_PIPE_STATUS_EN
  logic                 w_snan_in, w_denorm_in;
  logic                 r1_snan, r1_denorm, r2_snan, r2_denorm;
  logic [FLAG_BITS-1:0] w_flags;
  logic [FLAG_BITS-1:0] r3_flags;

  // A signalling NaN has the fraction MSB clear.
  assign w_snan_in   = ((w_cls_a == CLS_NAN) && !w_ma[MANT_BITS-1]) ||
                       ((w_cls_b == CLS_NAN) && !w_mb[MANT_BITS-1]);
  assign w_denorm_in = ((w_ea == '0) && (w_ma != '0)) ||
                       ((w_eb == '0) && (w_mb != '0));

  always_ff @(posedge clk) begin
    if (w_adv) begin
      if (in_valid) begin
        r1_snan   <= w_snan_in;
        r1_denorm <= w_denorm_in;
      end
      if (r1_valid) begin
        r2_snan   <= r1_snan;
        r2_denorm <= r1_denorm;
      end
    end
  end

  always_comb begin
    w_flags                 = '0;
    w_flags[FLAG_INVALID]   = r2_snan || w_inf_zero;
    w_flags[FLAG_OVERFLOW]  = !w_special && w_rp_ovf;
    w_flags[FLAG_UNDERFLOW] = !w_special && w_rp_unf;
    w_flags[FLAG_INEXACT]   = !w_special && w_rp_inx;
    w_flags[FLAG_DENORM]    = r2_denorm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r3_flags <= '0;
    end else if (w_adv && r2_valid) begin
      r3_flags <= w_flags;
    end
  end

  assign out_flags = r3_flags;
`else
  logic w_unused_status;
  assign w_unused_status = ^{w_rp_ovf, w_rp_unf, w_rp_inx, w_special};
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed and randomized checks for fp_mul_pipe in its fp32 configuration.
module tb_fp_mul_pipe;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [4:0]  f;   // {invalid, overflow, underflow, inexact, input_denorm}
  } vec_t;

  localparam int NV     = 18;
  localparam int N_RAND = 10000;

  localparam vec_t VEC [NV] = '{
    '{32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000},
    '{32'hBF800000, 32'h3F000000, 32'hBF000000, 5'b00000},
    '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'b00010},
    '{32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00010},
    '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 5'b01010},
    '{32'h00800000, 32'h3F000000, 32'h00000000, 5'b00110},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b10000},
    '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000},
    '{32'h00000001, 32'h3F800000, 32'h00000000, 5'b00001},
    '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000},
    '{32'h7FC00000, 32'h00000000, 32'h7FC00000, 5'b00000},
    '{32'h80000000, 32'h3F800000, 32'h80000000, 5'b00000},
    '{32'hFF800000, 32'hFF800000, 32'h7F800000, 5'b00000},
    '{32'h3F7FFFFF, 32'h3F800001, 32'h3F800000, 5'b00010},
    '{32'h7F7FFFFF, 32'h3F800001, 32'h7F800000, 5'b01010},
    '{32'h00800000, 32'h3F800000, 32'h00800000, 5'b00000},
    '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 5'b00000},
    '{32'hFFC00000, 32'h7F800000, 32'h7FC00000, 5'b00000}
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef FP_MUL_PIPE_STATUS_EN
  logic [4:0]  out_flags;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_mul_pipe #(
    .EXP_BITS  (8),
    .MANT_BITS (23)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FP_MUL_PIPE_STATUS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  // Reference: exact product in double precision, then RNE to fp32 with FTZ.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    real         ra, rb, p;
    logic [63:0] d;
    int          fe;
    logic [23:0] m;
    logic        g, st;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    ra = $bitstoreal({1'b0, 11'(int'(a[30:23]) + 896), a[22:0], 29'd0});
    rb = $bitstoreal({1'b0, 11'(int'(b[30:23]) + 896), b[22:0], 29'd0});
    p  = ra * rb;
    d  = $realtobits(p);
    fe = int'(d[62:52]) - 896;
    m  = {1'b0, d[51:29]};
    g  = d[28];
    st = |d[27:0];
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) fe = fe + 1;
    if (fe >= 255) return {s, 8'hFF, 23'd0};
    if (fe <= 0) return {s, 31'd0};
    return {s, fe[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [7:0] e;
    if ($urandom_range(0, 31) == 0) e = 8'd0;
    else if ($urandom_range(0, 7) == 0) e = 8'($urandom_range(1, 254));
    else e = 8'($urandom_range(64, 190));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (out_data !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_out_data: got %h want 00000000", out_data);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
`ifdef FP_MUL_PIPE_STATUS_EN
    n_cmp++;
    if (out_flags !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_out_flags: got %b want 00000", out_flags);
    end
`endif
  endtask

  task automatic test_directed();
    logic [2:0] seen;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_a      = VEC[i].a;
      in_b      = VEC[i].b;
      out_ready = 1'b1;
      @(posedge clk);
      seen = '0;
      for (int n = 0; n < 3; n++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        seen[n] = out_valid;
      end
      n_cmp++;
      if (seen !== 3'b100) begin
        n_bad++;
        $display("FAIL latency[%0d]: out_valid over cycles 3..1 got %b want 100", i, seen);
      end
      n_cmp++;
      if (out_data !== VEC[i].y) begin
        n_bad++;
        $display("FAIL data[%0d] %h x %h: got %h want %h", i, VEC[i].a, VEC[i].b, out_data, VEC[i].y);
      end
`ifdef FP_MUL_PIPE_STATUS_EN
      n_cmp++;
      if (out_flags !== VEC[i].f) begin
        n_bad++;
        $display("FAIL flags[%0d] %h x %h: got %b want %b", i, VEC[i].a, VEC[i].b, out_flags, VEC[i].f);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] want;
    logic [31:0] prev_data;
    logic        prev_stall;
    int          sent;
    int          got;
    sent       = 0;
    got        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c < 9);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        in_a = VEC[sent].a;
        in_b = VEC[sent].b;
      end
      #1;
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_bad++;
          $display("FAIL stall_hold c%0d: got v=%b %h want v=1 %h", c, out_valid, out_data, prev_data);
        end
      end
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL stall_in_ready c%0d: got %b want 0", c, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_extra c%0d: got %h want no result", c, out_data);
        end else begin
          want = exp_q.pop_front();
          if (out_data !== want) begin
            n_bad++;
            $display("FAIL b2b_data c%0d: got %h want %h", c, out_data, want);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(VEC[sent].y);
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got !== 6 || sent !== 6) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d results/%0d sent want 6/6", got, sent);
    end
  endtask

  task automatic test_reset_midstream();
    logic [2:0] seen;
    logic       stale;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = VEC[i].a;
      in_b     = VEC[i].b;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'd0) begin
      n_bad++;
      $display("FAIL midrst_clear: got v=%b %h want v=0 00000000", out_valid, out_data);
    end
`ifdef FP_MUL_PIPE_STATUS_EN
    n_cmp++;
    if (out_flags !== 5'd0) begin
      n_bad++;
      $display("FAIL midrst_flags: got %b want 00000", out_flags);
    end
`endif
    out_ready = 1'b1;
    stale     = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      #1;
      if (out_valid) stale = 1'b1;
    end
    n_cmp++;
    if (stale !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_stale: got out_valid=%b after reset want 0", stale);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = VEC[3].a;
    in_b     = VEC[3].b;
    @(posedge clk);
    seen = '0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      seen[n] = out_valid;
    end
    n_cmp++;
    if (seen !== 3'b100) begin
      n_bad++;
      $display("FAIL midrst_latency: out_valid over cycles 3..1 got %b want 100", seen);
    end
    n_cmp++;
    if (out_data !== VEC[3].y) begin
      n_bad++;
      $display("FAIL midrst_data: got %h want %h", out_data, VEC[3].y);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] want;
    logic [31:0] ra, rb;
    logic        pend;
    int          sent;
    int          got;
    int          cyc;
    pend = 1'b0;
    sent = 0;
    got  = 0;
    cyc  = 0;
    ra   = '0;
    rb   = '0;
    while (got < N_RAND && cyc < 60000) begin
      @(negedge clk);
      if (!pend && sent < N_RAND && $urandom_range(0, 9) < 7) begin
        ra   = gen_operand();
        rb   = gen_operand();
        pend = 1'b1;
      end
      in_valid  = pend;
      in_a      = ra;
      in_b      = rb;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rand_extra: got %h want no result", out_data);
        end else begin
          want = exp_q.pop_front();
          if (out_data !== want) begin
            n_bad++;
            $display("FAIL rand_data #%0d: got %h want %h", got, out_data, want);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul(ra, rb));
        pend = 1'b0;
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got !== N_RAND) begin
      n_bad++;
      $display("FAIL rand_count: got %0d results want %0d", got, N_RAND);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
